bram_port_ctrl: RTL and testbench

BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

---
 rtl/xil_pkg.sv | 24 ++
 rtl/bram_rsp_fifo.sv | 58 +++++
 rtl/bram_port_ctrl.sv | 65 ++++++
 tb/tb_bram_port_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xil_pkg.sv
// Shared constants and types for the BRAM port controller and its response FIFO.
package xil_pkg;

    localparam int unsigned CREDIT_MAX = 3;
    localparam int unsigned DEF_SIZE   = 1024;
    localparam int unsigned DEF_WIDTH  = 256;

    // Request record at the default geometry; other instances carry the same fields as
    // separate ports sized by their own SIZE/WIDTH.
    typedef struct packed {
        logic                        we;
        logic [$clog2(DEF_SIZE)-1:0] addr;
        logic [DEF_WIDTH-1:0]        wdata;
    } bram_req_t;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(CREDIT_MAX - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic credit_avail(input logic [1:0] occ, input logic inflight);
        return ({1'b0, occ} + {2'b00, inflight}) < 3'(CREDIT_MAX);
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Three-entry response FIFO with occupancy count and modulo-3 head/tail pointers.
module bram_rsp_fifo
    import xil_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [CREDIT_MAX];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign not_empty = (count_q != 2'd0);
    assign count     = count_q;

    // The upstream credit rule must make this unreachable.
    assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'(CREDIT_MAX)));

endmodule

// File: rtl/bram_port_ctrl.sv
// Request/response wrapper around one registered BRAM port with credit-based flow control.
module bram_port_ctrl
    import xil_pkg::*;
#(
    parameter int unsigned SIZE          = 1024,
    parameter int unsigned WIDTH         = 256,
    parameter bit          RESP_ON_WRITE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [$clog2(SIZE)-1:0] req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [$clog2(SIZE)-1:0] bram_addr,
    output logic [WIDTH-1:0]        bram_di,
    input  logic [WIDTH-1:0]        bram_do
);

    logic       inflight;
    logic [1:0] occ;
    logic       accept;
    logic       responding;
    logic       fifo_not_empty;

    // Depends only on registered state and rst, never on rsp_ready.
    assign req_ready  = !rst && credit_avail(occ, inflight);
    assign accept     = req_valid && req_ready;
    assign responding = !req_we || RESP_ON_WRITE;

    assign bram_en   = accept;
    assign bram_we   = req_we && accept;
    assign bram_addr = req_addr;
    assign bram_di   = req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept && responding;
        end
    end

    bram_rsp_fifo #(
        .WIDTH (WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bram_do),
        .pop       (rsp_ready),
        .head_data (rsp_data),
        .not_empty (fifo_not_empty),
        .count     (occ)
    );

    assign rsp_valid = fifo_not_empty && !rst;

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Bench for bram_port_ctrl: directed vector table, corner sequences, random scoreboard run.
module tb_bram_port_ctrl;

    localparam int unsigned SIZE  = 64;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a, req_valid_a, req_ready_a, req_we_a, rsp_valid_a, rsp_ready_a;
    logic [AW-1:0]    req_addr_a, bram_addr_a;
    logic [WIDTH-1:0] req_wdata_a, rsp_data_a, bram_di_a, bram_do_a;
    logic             bram_en_a, bram_we_a, preload_a;

    logic             rst_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b;
    logic [AW-1:0]    req_addr_b, bram_addr_b;
    logic [WIDTH-1:0] req_wdata_b, rsp_data_b, bram_di_b, bram_do_b;
    logic             bram_en_b, bram_we_b, preload_b;

    bram_port_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .RESP_ON_WRITE(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
        .bram_en(bram_en_a), .bram_we(bram_we_a), .bram_addr(bram_addr_a),
        .bram_di(bram_di_a), .bram_do(bram_do_a)
    );

    bram_port_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .RESP_ON_WRITE(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .bram_en(bram_en_b), .bram_we(bram_we_b), .bram_addr(bram_addr_b),
        .bram_di(bram_di_b), .bram_do(bram_do_b)
    );

    // Registered, read-first BRAM models for the two ports.
    logic [WIDTH-1:0] mem_a [SIZE];
    logic [WIDTH-1:0] mem_b [SIZE];

    always @(posedge clk) begin
        if (preload_a) begin
            for (int i = 0; i < SIZE; i++) mem_a[i] <= WIDTH'(i);
        end else if (bram_en_a) begin
            bram_do_a <= mem_a[bram_addr_a];
            if (bram_we_a) mem_a[bram_addr_a] <= bram_di_a;
        end
    end

    always @(posedge clk) begin
        if (preload_b) begin
            for (int i = 0; i < SIZE; i++) mem_b[i] <= (i == 7) ? 32'h11 : WIDTH'(i);
        end else if (bram_en_b) begin
            bram_do_b <= mem_b[bram_addr_b];
            if (bram_we_b) mem_b[bram_addr_b] <= bram_di_b;
        end
    end

    typedef struct {
        logic             valid;
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
        logic             rr;
        logic             exp_ready;
        logic             exp_rv;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    vec_t             vecs [18];
    logic [WIDTH-1:0] ref_mem [SIZE];
    logic [WIDTH-1:0] expq [$];
    int               n_cmp = 0;
    int               n_fail = 0;
    int               n_rsp = 0;
    bit               acc_seen;
    bit               hold_pend;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] last_rsp;

    function automatic vec_t mk(bit v, bit we, int a, logic [WIDTH-1:0] wd, bit rr, bit er,
                                bit ev, logic [WIDTH-1:0] ed);
        vec_t r;
        r.valid = v; r.we = we; r.addr = AW'(a); r.wdata = wd; r.rr = rr;
        r.exp_ready = er; r.exp_rv = ev; r.exp_data = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard for port A, sampled mid-cycle before the edge that commits handshakes.
    task automatic monitor_a();
        acc_seen = 1'b0;
        if (rst_a) begin
            expq.delete();
            hold_pend = 1'b0;
            return;
        end
        if (hold_pend) begin
            chk("rsp_hold_valid", rsp_valid_a, 1);
            chk("rsp_hold_data", rsp_data_a, hold_data);
        end
        if (rsp_valid_a && rsp_ready_a) begin
            n_rsp++;
            last_rsp = rsp_data_a;
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got %h expected none", rsp_data_a);
            end else begin
                chk("rsp_data", rsp_data_a, expq.pop_front());
            end
        end
        if (req_valid_a && req_ready_a) begin
            acc_seen = 1'b1;
            if (req_we_a) ref_mem[req_addr_a] = req_wdata_a;
            else          expq.push_back(ref_mem[req_addr_a]);
        end
        hold_pend = rsp_valid_a && !rsp_ready_a;
        hold_data = rsp_data_a;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor_a();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid_a = 1'b1; req_we_a = we; req_addr_a = a; req_wdata_a = d;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (acc_seen) break;
        end
        chk("send_accept", acc_seen, 1);
        req_valid_a = 1'b0;
    endtask

    task automatic drain();
        req_valid_a = 1'b0;
        rsp_ready_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (expq.size() == 0 && !rsp_valid_a) break;
        end
        chk("drain_empty", expq.size(), 0);
    endtask

    task automatic b_xact(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          output logic [WIDTH-1:0] data, output int lat);
        bit got;
        req_valid_b = 1'b1; req_we_b = we; req_addr_b = a; req_wdata_b = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready_b;
            @(posedge clk);
            #1;
        end
        chk("b_accept", got, 1);
        req_valid_b = 1'b0;
        lat = 0;
        data = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid_b) begin
                lat = k;
                data = rsp_data_b;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int               base, n_req, n_rd, cycles, lat;
        logic [WIDTH-1:0] bdata;

        for (int i = 0; i < 10; i++)
            vecs[i] = mk(1, 0, i, '0, 1, 1, i >= 2, (i >= 2) ? WIDTH'(i - 2) : '0);
        vecs[10] = mk(0, 0, 0, '0, 1, 1, 1, 32'd8);
        vecs[11] = mk(0, 0, 0, '0, 1, 1, 1, 32'd9);
        vecs[12] = mk(0, 0, 0, '0, 1, 1, 0, '0);
        vecs[13] = mk(1, 1, 5, 32'hA5, 1, 1, 0, '0);
        vecs[14] = mk(1, 0, 5, '0, 1, 1, 0, '0);
        vecs[15] = mk(0, 0, 0, '0, 1, 1, 0, '0);
        vecs[16] = mk(0, 0, 0, '0, 1, 1, 1, 32'hA5);
        vecs[17] = mk(0, 0, 0, '0, 1, 1, 0, '0);

        for (int i = 0; i < SIZE; i++) ref_mem[i] = WIDTH'(i);
        hold_pend = 1'b0;
        last_rsp = '0;

        rst_a = 1'b1; preload_a = 1'b1; req_valid_a = 1'b1; req_we_a = 1'b1;
        req_addr_a = '0; req_wdata_a = '1; rsp_ready_a = 1'b0;
        rst_b = 1'b1; preload_b = 1'b1; req_valid_b = 1'b0; req_we_b = 1'b0;
        req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", req_ready_a, 0);
        chk("rst_bram_en", bram_en_a, 0);
        chk("rst_bram_we", bram_we_a, 0);
        chk("rst_rsp_valid", rsp_valid_a, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0; preload_a = 1'b0; req_valid_a = 1'b0;
        rst_b = 1'b0; preload_b = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready_a, 1);
        chk("post_rst_rsp_valid", rsp_valid_a, 0);
        @(posedge clk);
        #1;

        // Back-to-back reads, then write/read to the same address.
        for (int i = 0; i < 18; i++) begin
            req_valid_a = vecs[i].valid; req_we_a = vecs[i].we;
            req_addr_a = vecs[i].addr; req_wdata_a = vecs[i].wdata; rsp_ready_a = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), req_ready_a, vecs[i].exp_ready);
            chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid_a, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk($sformatf("tbl%0d_rsp_data", i), rsp_data_a, vecs[i].exp_data);
            monitor_a();
            @(posedge clk);
            #1;
        end

        // Credit exhaustion with the consumer stalled.
        base = n_rsp;
        rsp_ready_a = 1'b0;
        send(0, 0, '0);
        send(0, 1, '0);
        send(0, 2, '0);
        req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 3;
        n_req = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("full_ready_low", req_ready_a, 0);
            monitor_a();
            if (acc_seen) n_req++;
            @(posedge clk);
            #1;
        end
        chk("full_accept_count", n_req, 0);
        chk("full_head_valid", rsp_valid_a, 1);
        chk("full_head_data", rsp_data_a, 32'd0);
        rsp_ready_a = 1'b1;
        send(0, 3, '0);
        send(0, 4, '0);
        drain();
        chk("full_rsp_count", n_rsp - base, 5);

        // Reset with responses buffered and in flight.
        rsp_ready_a = 1'b0;
        send(1, 3, 32'h33);
        send(0, 1, '0);
        send(0, 2, '0);
        rst_a = 1'b1; req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 9;
        @(negedge clk);
        chk("mid_rst_ready", req_ready_a, 0);
        chk("mid_rst_bram_en", bram_en_a, 0);
        chk("mid_rst_bram_we", bram_we_a, 0);
        chk("mid_rst_rsp_valid", rsp_valid_a, 0);
        monitor_a();
        @(posedge clk);
        #1;
        rst_a = 1'b0; req_valid_a = 1'b0; rsp_ready_a = 1'b1;
        base = n_rsp;
        @(negedge clk);
        chk("rst_release_ready", req_ready_a, 1);
        monitor_a();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("post_rst_no_rsp", rsp_valid_a, 0);
        end
        send(0, 3, '0);
        drain();
        chk("rst_rsp_count", n_rsp - base, 1);
        chk("rst_read_data", last_rsp, 32'h33);

        // Read-first response on writes from the second instance.
        b_xact(1, 7, 32'h22, bdata, lat);
        chk("row_write_rsp", bdata, 32'h11);
        chk("row_write_lat", lat, 2);
        b_xact(0, 7, '0, bdata, lat);
        chk("row_read_rsp", bdata, 32'h22);
        chk("row_read_lat", lat, 2);

        // Random traffic against the reference memory.
        base = n_rsp; n_req = 0; n_rd = 0; cycles = 0;
        while (n_req < 10000 && cycles < 60000) begin
            req_valid_a = ($urandom_range(9) < 7);
            req_we_a    = $urandom_range(1) == 1;
            req_addr_a  = AW'($urandom_range(15));
            req_wdata_a = $urandom;
            rsp_ready_a = ($urandom_range(9) < 6);
            cyc();
            if (acc_seen) begin
                n_req++;
                if (!req_we_a) n_rd++;
            end
            cycles++;
        end
        chk("rand_req_count", n_req, 10000);
        drain();
        chk("rand_rsp_count", n_rsp - base, n_rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
